// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined CLA subtractor.
package cla_pkg;

  localparam int CLA_WIDTH  = 8;
  localparam int CLA_SLICE  = 4;
  localparam int CLA_HALF   = CLA_WIDTH / 2;
  localparam int CLA_NSLICE = CLA_HALF / CLA_SLICE;

  typedef logic [CLA_SLICE-1:0] slice_t;

  typedef struct packed {
    logic p;
    logic g;
  } pg_t;

endpackage

// File: rtl/cla_sub_pipe_if.sv
// Valid/ready operand and result bus of the pipelined CLA subtractor.
interface cla_sub_pipe_if #(parameter int WIDTH = cla_pkg::CLA_WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Zero;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, Zero
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, Zero
  );

endinterface

// File: rtl/cla_slice.sv
// SLICE-bit combinational carry-lookahead adder with group propagate/generate.
module cla_slice
  import cla_pkg::*;
#(
  parameter int SLICE = CLA_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output pg_t              pg
);

  logic [SLICE-1:0] p_s;
  logic [SLICE-1:0] g_s;
  logic [SLICE-1:0] c_s;
  logic             term_s;
  logic             gterm_s;
  logic             gg_s;

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Each bit carry as a flat sum of products: cin & P[i-1:0] | G_j & P[i-1:j+1].
  always_comb begin
    c_s    = {SLICE{1'b0}};
    term_s = 1'b0;
    for (int i = 0; i < SLICE; i++) begin
      term_s = cin;
      for (int j = 0; j < i; j++) term_s = term_s & p_s[j];
      c_s[i] = term_s;
      for (int j = 0; j < i; j++) begin
        term_s = g_s[j];
        for (int k = j + 1; k < i; k++) term_s = term_s & p_s[k];
        c_s[i] = c_s[i] | term_s;
      end
    end
  end

  assign s = p_s ^ c_s;

  // Group terms depend on a/b only, keeping the inter-slice chain loop-free.
  always_comb begin
    gg_s    = 1'b0;
    gterm_s = 1'b0;
    for (int j = 0; j < SLICE; j++) begin
      gterm_s = g_s[j];
      for (int k = j + 1; k < SLICE; k++) gterm_s = gterm_s & p_s[k];
      gg_s = gg_s | gterm_s;
    end
    pg.p = &p_s;
    pg.g = gg_s;
  end

endmodule

// File: rtl/cla_sub_pipe.sv
// Two-stage pipelined subtractor D = A - B - Bin as A + ~B + ~Bin on CLA slices.
// Optional CLA_SUB_SAT_EN: clamp D to zero (Zero=1) whenever a borrow occurs.
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH,
  parameter int SLICE = CLA_SLICE
) (
  input  logic           clk,
  input  logic           rst_n,
  cla_sub_pipe_if.slave  bus
);

  localparam int HALF   = WIDTH / 2;
  localparam int NSLICE = HALF / SLICE;

  logic              s1_valid_r;
  logic [HALF-1:0]   s1_lo_r;
  logic              s1_cmid_r;
  logic [HALF-1:0]   s1_a_hi_r;
  logic [HALF-1:0]   s1_nb_hi_r;
  logic              s2_valid_r;
  logic [WIDTH-1:0]  d_r;
  logic              bout_r;
  logic              zero_r;

  logic              s2_adv_s;
  logic              s1_adv_s;
  logic [HALF-1:0]   nb_lo_s;
  logic [HALF-1:0]   lo_sum_s;
  logic [HALF-1:0]   hi_sum_s;
  logic [NSLICE:0]   c1_s;
  logic [NSLICE:0]   c2_s;
  pg_t  [NSLICE-1:0] pg1_s;
  pg_t  [NSLICE-1:0] pg2_s;
  logic [WIDTH-1:0]  d_raw_s;
  logic              bout_s;
  logic [WIDTH-1:0]  d_nxt_s;
  logic              zero_nxt_s;

  assign s2_adv_s = !s2_valid_r || bus.out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign nb_lo_s  = ~bus.B[HALF-1:0];

  for (genvar k = 0; k < NSLICE; k++) begin : g_lo
    cla_slice #(.SLICE(SLICE)) u_slice (
      .a   (bus.A[k*SLICE +: SLICE]),
      .b   (nb_lo_s[k*SLICE +: SLICE]),
      .cin (c1_s[k]),
      .s   (lo_sum_s[k*SLICE +: SLICE]),
      .pg  (pg1_s[k])
    );
  end

  for (genvar k = 0; k < NSLICE; k++) begin : g_hi
    cla_slice #(.SLICE(SLICE)) u_slice (
      .a   (s1_a_hi_r[k*SLICE +: SLICE]),
      .b   (s1_nb_hi_r[k*SLICE +: SLICE]),
      .cin (c2_s[k]),
      .s   (hi_sum_s[k*SLICE +: SLICE]),
      .pg  (pg2_s[k])
    );
  end

  // Group lookahead chains; the low half starts from the inverted borrow-in.
  always_comb begin
    c1_s    = {(NSLICE+1){1'b0}};
    c2_s    = {(NSLICE+1){1'b0}};
    c1_s[0] = ~bus.Bin;
    c2_s[0] = s1_cmid_r;
    for (int k = 0; k < NSLICE; k++) begin
      c1_s[k+1] = pg1_s[k].g | (pg1_s[k].p & c1_s[k]);
      c2_s[k+1] = pg2_s[k].g | (pg2_s[k].p & c2_s[k]);
    end
  end

  assign d_raw_s = {hi_sum_s, s1_lo_r};
  assign bout_s  = ~c2_s[NSLICE];

  // Stage-2 result mux: modulo wrap, or clamp on borrow in the saturating build.
  always_comb begin
    d_nxt_s    = d_raw_s;
    zero_nxt_s = (d_raw_s == {WIDTH{1'b0}});
`ifdef CLA_SUB_SAT_EN
    if (bout_s) begin
      d_nxt_s    = {WIDTH{1'b0}};
      zero_nxt_s = 1'b1;
    end else begin
      d_nxt_s    = d_raw_s;
      zero_nxt_s = (d_raw_s == {WIDTH{1'b0}});
    end
`endif
  end

  // Stage 1: low-half difference, mid carry and the high-half operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_lo_r    <= {HALF{1'b0}};
      s1_cmid_r  <= 1'b0;
      s1_a_hi_r  <= {HALF{1'b0}};
      s1_nb_hi_r <= {HALF{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_lo_r    <= lo_sum_s;
        s1_cmid_r  <= c1_s[NSLICE];
        s1_a_hi_r  <= bus.A[WIDTH-1:HALF];
        s1_nb_hi_r <= ~bus.B[WIDTH-1:HALF];
      end
    end
  end

  // Stage 2: registered result; held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      d_r        <= {WIDTH{1'b0}};
      bout_r     <= 1'b0;
      zero_r     <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        d_r    <= d_nxt_s;
        bout_r <= bout_s;
        zero_r <= zero_nxt_s;
      end
    end
  end

  assign bus.in_ready  = s1_adv_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.D         = d_r;
  assign bus.Bout      = bout_r;
  assign bus.Zero      = zero_r;

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: vector table, stall/reset sequences, random scoreboard.
module tb_cla_sub_pipe;

  logic clk;
  logic rst_n;

  cla_sub_pipe_if #(.WIDTH(8)) bus ();

  cla_sub_pipe #(.WIDTH(8), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       zero;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] exp_q [$];
  int         n_cmp;
  int         n_err;
  int         n_out;

  logic       smp_in_ready;
  logic       smp_out_valid;
  logic [7:0] smp_d;
  logic       smp_bout;
  logic       smp_zero;
  logic       prev_stall;
  logic [9:0] prev_res;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Reference: (9-bit) A - B - Bin; borrow is the top bit.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    logic [7:0] d;
    logic       bo;
    r  = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    bo = r[8];
    d  = r[7:0];
`ifdef CLA_SUB_SAT_EN
    if (bo) d = 8'h00;
`endif
    return {(d == 8'h00), bo, d};
  endfunction

  // One clock: drive at posedge+1, sample mid-cycle, score, advance to next posedge+1.
  task automatic cyc(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic bin, input logic ordy);
    logic [9:0] e;
    bus.in_valid  = iv;
    bus.A         = a;
    bus.B         = b;
    bus.Bin       = bin;
    bus.out_ready = ordy;
    #3;
    smp_in_ready  = bus.in_ready;
    smp_out_valid = bus.out_valid;
    smp_d         = bus.D;
    smp_bout      = bus.Bout;
    smp_zero      = bus.Zero;
    if (prev_stall) begin
      check("hold_valid", n_out, 32'(smp_out_valid), 32'd1);
      check("hold_res", n_out, 32'({smp_zero, smp_bout, smp_d}), 32'(prev_res));
    end
    if (smp_out_valid && ordy) begin
      check("sb_nonempty", n_out, 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_d", n_out, 32'(smp_d), 32'(e[7:0]));
        check("sb_bout", n_out, 32'(smp_bout), 32'(e[8]));
        check("sb_zero", n_out, 32'(smp_zero), 32'(e[9]));
      end
      n_out++;
    end
    if (iv && smp_in_ready) exp_q.push_back(model(a, b, bin));
    prev_stall = smp_out_valid && !ordy;
    prev_res   = {smp_zero, smp_bout, smp_d};
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    int         acc;
    int         ncyc;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbin;
    logic       riv;

    n_cmp = 0; n_err = 0; n_out = 0;
    prev_stall = 1'b0; prev_res = 10'd0;
    vecs[0] = '{8'h55, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[3] = '{8'hF0, 8'h0F, 1'b1, 8'hE0, 1'b0, 1'b0};
    vecs[4] = '{8'hA5, 8'hA5, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0};
`ifdef CLA_SUB_SAT_EN
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].bout) begin
        vecs[i].d    = 8'h00;
        vecs[i].zero = 1'b1;
      end
    end
`endif

    // Reset state
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.A = 8'h00; bus.B = 8'h00; bus.Bin = 1'b0; bus.out_ready = 1'b0;
    #12;
    check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    check("rst_d", 0, 32'(bus.D), 32'd0);
    check("rst_bout", 0, 32'(bus.Bout), 32'd0);
    check("rst_zero", 0, 32'(bus.Zero), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 0, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Vector table, one isolated transaction each, with latency check
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1);
      check("tbl_in_ready", i, 32'(smp_in_ready), 32'd1);
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("tbl_lat1", i, 32'(smp_out_valid), 32'd0);
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("tbl_lat2", i, 32'(smp_out_valid), 32'd1);
      check("tbl_d", i, 32'(smp_d), 32'(vecs[i].d));
      check("tbl_bout", i, 32'(smp_bout), 32'(vecs[i].bout));
      check("tbl_zero", i, 32'(smp_zero), 32'(vecs[i].zero));
    end

    // Back-to-back stream with a 4-cycle consumer stall
    cyc(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0);
    check("stall_rdy0", 0, 32'(smp_in_ready), 32'd1);
    cyc(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0);
    check("stall_rdy1", 0, 32'(smp_in_ready), 32'd1);
    cyc(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0);
    check("stall_rdy2", 0, 32'(smp_in_ready), 32'd0);
    check("stall_d2", 0, 32'(smp_d), 32'h4B);
    cyc(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b0);
    check("stall_rdy3", 0, 32'(smp_in_ready), 32'd0);
    check("stall_d3", 0, 32'(smp_d), 32'h4B);
    cyc(1'b1, 8'h0F, 8'h0F, 1'b0, 1'b1);
    check("stall_full_adv", 0, 32'(smp_in_ready), 32'd1);
    check("stall_out0", 0, 32'(smp_d), 32'h4B);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("stall_out1", 0, 32'(smp_d), 32'hFE);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("stall_out2v", 0, 32'(smp_out_valid), 32'd1);
    check("stall_out2", 0, 32'(smp_d), 32'h00);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("stall_drained", 0, 32'(smp_out_valid), 32'd0);
    check("stall_sb_empty", 0, exp_q.size(), 32'd0);

    // Reset with both stages full and the consumer stalled
    cyc(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
    cyc(1'b1, 8'h33, 8'h11, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    check("mid_full", 0, 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 0, 32'(bus.out_valid), 32'd0);
    check("mid_rst_d", 0, 32'(bus.D), 32'd0);
    check("mid_rst_bout", 0, 32'(bus.Bout), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 0, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      check("mid_no_stale", i, 32'(smp_out_valid), 32'd0);
    end

    // Random traffic against the scoreboard
    acc  = 0;
    ncyc = 0;
    ra   = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
    while (acc < 10000 && ncyc < 60000) begin
      riv = ($urandom_range(3, 0) != 0);
      cyc(riv, ra, rb, rbin, ($urandom_range(3, 0) != 0));
      if (riv && smp_in_ready) begin
        acc++;
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      end
      ncyc++;
    end
    check("rand_budget", 0, acc, 32'd10000);
    for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("rand_sb_empty", 0, exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
